mon_sender: RTL and testbench
=============================

# mon_sender

Upstream stage of the monitor link: buffers bytes from a producer in a small FIFO and presents them on the 8-bit data bus read by the receiver. Advances to the next byte on each rising edge of the receiver-driven `sel` strobe. Tracks link health: idle, running, or starved, plus a saturating underrun counter.

## Interface
- `WIDTH`, 8, data word width; must match the receiver bus.
- `DEPTH`, 4, FIFO depth in words; power of two, at least 2.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `in_data`  in  WIDTH  producer word.
- `in_valid`  in  1  producer word valid.
- `in_ready`  out  1  FIFO can accept. Equals `!full`, registered-state only, with no combinational path from `sel`.
- `sel`  in  1  advance strobe from the receiver, synchronous to `clk`.
- `data`  out  WIDTH  word presented to the receiver.
- `link_state`  out  2  0 = IDLE, 1 = RUN, 2 = STARVED.
- `underrun_cnt`  out  8  count of advance requests made while the FIFO was empty; saturates at 255.

## Operation
- **Push.** When `in_valid && in_ready`, `in_data` is written at the write pointer and the pointer increments.
- **Advance request.** An advance request is `sel && !sel_q`, where `sel_q` is `sel` delayed one cycle. A request is only a rising edge; a high level held on `sel` produces one request.
- **Advance with data.** On a request with the FIFO non-empty, `data` is loaded from the FIFO head and the read pointer increments.
- **Advance without data.** On a request with the FIFO empty, `data` holds its value and `underrun_cnt` increments, saturating at 255.
- **Simultaneous push and request.**
  - If the FIFO is empty: the request is an underrun, the push is stored, and there is no bypass.
  - If the FIFO is full: no push occurs because `in_ready` = 0, and the pop proceeds.
  - Otherwise: both take effect and the occupancy is unchanged.
- **Pointers and occupancy.** Pointers are `$clog2(DEPTH)` bits wide and wrap naturally. Occupancy is a `$clog2(DEPTH)+1`-bit count. full = (count == DEPTH); empty = (count == 0).
- **FSM (`link_state`).**
  - IDLE → RUN on the first successful pop.
  - RUN → STARVED on an underrun.
  - STARVED → RUN on a successful pop.
  - IDLE stays IDLE on an underrun, but `underrun_cnt` still increments.
  - No other transitions.
- **Reset values.** `data` = 0, `link_state` = IDLE, `underrun_cnt` = 0, pointers/count = 0, `sel_q` = 0, `in_ready` = 1. FIFO storage is not reset.
- **Reset mid-operation.** Asserting `rst` low at any time clears all of the above immediately and discards FIFO contents. After `rst` deasserts, `sel_q` = 0, so a `sel` already high in the first cycle counts as a request.

## Timing
- **Push latency.** A word pushed in cycle N is poppable by a request detected in cycle N+1 or later.
- **Pop latency.** For a request detected in cycle N (i.e. `sel` rising seen in cycle N), `data`, `link_state` and `underrun_cnt` update at the clock edge ending cycle N and are visible in cycle N+1. Sampling `sel` through `sel_q` therefore gives 1-cycle latency from the `sel` rise.
- **Ready timing.** `in_ready` deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the pop that frees a slot.
- **Throughput.** With the receiver's 2-bit counter driving `sel` = cmpt[1], requests occur every 4 cycles. The producer may push every cycle until full.

## Structure
- Package `mon_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, STARVED} link_state_t`
  - `localparam MON_WIDTH = 8`
  - `localparam UNDERRUN_MAX = 8'hFF`
- One sub-module, `mon_fifo`: the storage array, pointers, count and full/empty flags, with push/pop ports.
- The top level keeps the edge detect, output register, FSM and counter.

## Test plan
- **Reset defaults.** Hold `rst` = 0 with `sel` toggling → `data` = 0, `link_state` = IDLE, `underrun_cnt` = 0, `in_ready` = 1 throughout.
- **In-order delivery.** Push 0x11, 0x22, 0x33, then raise `sel` three times, 4 cycles apart → `data` reads 0x11, 0x22, 0x33, each one cycle after the `sel` rise. `link_state` = RUN.
- **Full handling.** Push 5 words with `DEPTH` = 4 and no `sel` → `in_ready` = 0 after the 4th push and the 5th word is not accepted. One `sel` rise → `data` = word 1 and `in_ready` = 1 the following cycle.
- **Underrun and recovery.** With the FIFO empty after RUN, give 2 `sel` rises → `underrun_cnt` = 2, `link_state` = STARVED, `data` unchanged. Then push 0x5A and give a `sel` rise → `data` = 0x5A, `link_state` = RUN.
- **Saturation.** Give 300 `sel` rises with the FIFO empty → `underrun_cnt` = 255, `link_state` stays IDLE.
- **Push with simultaneous request, and reset mid-stream.**
  - Push into an empty FIFO in the same cycle as a request → underrun is counted and the word is popped by the next request.
  - With 2 words queued, assert `rst` low for 1 cycle → all outputs return to reset values and a subsequent request underruns.

Source files
------------

// File: rtl/mon_pkg.sv
// Shared definitions for the monitor link sender.
//   link_state_t : link health encoding (IDLE / RUN / STARVED)
//   MON_WIDTH    : default data word width on the receiver bus
//   UNDERRUN_MAX : saturation value of the underrun counter
//   sat_inc8     : saturating 8-bit increment helper
package mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STARVED = 2'd2
    } link_state_t;

    localparam int         MON_WIDTH    = 8;
    localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

    // Increment by one, holding at UNDERRUN_MAX.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == UNDERRUN_MAX) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/mon_fifo.sv
// Small synchronous FIFO feeding the monitor link sender.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_push, i_data  : write request and word (ignored while full)
//   i_pop           : read request (ignored while empty)
//   o_head          : word at the read pointer
//   o_full, o_empty : registered occupancy flags
// Storage is not reset; pointers, count and flags are.
module mon_fifo
    import mon_pkg::*;
#(
    parameter int WIDTH = MON_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_push;
    logic             w_do_pop;
    logic [CW-1:0]    w_count_nxt;

    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty;

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_nxt = r_count - CW'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Pointers, count and flags; flags are registered so in_ready has no path from sel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == CW'(0));
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/mon_sender.sv
// Monitor link sender: buffers producer words and presents one on `data`
// per rising edge of the receiver's `sel` strobe, tracking link health.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   in_data, in_valid   : producer word and valid
//   in_ready            : FIFO not full (registered state only)
//   sel                 : advance strobe from the receiver
//   data                : word presented to the receiver
//   link_state          : 0 IDLE, 1 RUN, 2 STARVED
//   underrun_cnt        : saturating count of requests made while empty
module mon_sender
    import mon_pkg::*;
#(
    parameter int WIDTH = MON_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       link_state,
    output logic [7:0]       underrun_cnt
);

    logic             r_sel_q;
    logic [WIDTH-1:0] r_data;
    link_state_t      r_state;
    logic [7:0]       r_underrun_cnt;

    logic             w_req;
    logic             w_pop;
    logic             w_underrun;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head;

    // A request is a rising edge of sel; a held-high sel yields one request.
    assign w_req      = sel && !r_sel_q;
    assign w_pop      = w_req && !w_empty;
    assign w_underrun = w_req && w_empty;
    // An empty FIFO never bypasses: a same-cycle push is stored, the request underruns.
    assign w_push     = in_valid && !w_full;

    mon_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Edge detect, output word register, link FSM and underrun counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel_q        <= 1'b0;
            r_data         <= '0;
            r_state        <= IDLE;
            r_underrun_cnt <= 8'd0;
        end else begin
            r_sel_q <= sel;
            if (w_pop) begin
                r_data <= w_head;
            end
            if (w_underrun) begin
                r_underrun_cnt <= sat_inc8(r_underrun_cnt);
            end
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_underrun) begin
                        r_state <= STARVED;
                    end
                end
                STARVED: begin
                    if (w_pop) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = !w_full;
    assign data         = r_data;
    assign link_state   = r_state;
    assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_mon_sender.sv
// Self-checking bench for mon_sender: directed scenarios followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_mon_sender;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       sel;
    logic [7:0] data;
    logic [1:0] link_state;
    logic [7:0] underrun_cnt;

    int nvec;
    int nerr;

    // Behavioural model: FIFO contents as a queue plus the visible outputs.
    logic [7:0] q[$];
    logic [7:0] m_data;
    int         m_state;   // 0 IDLE, 1 RUN, 2 STARVED
    int         m_cnt;
    bit         m_prev_sel;

    mon_sender #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sel          (sel),
        .data         (data),
        .link_state   (link_state),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},  {24'd0, data}, {24'd0, m_data});
        chk({tag, ".state"}, {30'd0, link_state}, m_state);
        chk({tag, ".ucnt"},  {24'd0, underrun_cnt}, m_cnt);
        chk({tag, ".ready"}, {31'd0, in_ready}, (q.size() < DEPTH) ? 32'd1 : 32'd0);
    endtask

    task automatic model_clear();
        q.delete();
        m_data     = 8'd0;
        m_state    = 0;
        m_cnt      = 0;
        m_prev_sel = 1'b0;
    endtask

    // One clock with the given inputs; the model applies the rules, then outputs are checked.
    task automatic cycle(input bit v, input logic [7:0] d, input bit s, input string tag);
        bit req;
        bit rdy;
        in_valid = v;
        in_data  = d;
        sel      = s;
        req = s && !m_prev_sel;
        rdy = (q.size() < DEPTH);
        if (req) begin
            if (q.size() > 0) begin
                m_data  = q.pop_front();
                m_state = 1;
            end else begin
                if (m_cnt < 255) m_cnt++;
                if (m_state == 1) m_state = 2;
            end
        end
        if (v && rdy) q.push_back(d);
        m_prev_sel = s;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse lasting one clock edge, launched away from the edge.
    task automatic do_reset();
        rst      = 1'b0;
        sel      = 1'b0;
        in_valid = 1'b0;
        model_clear();
        #1;
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b1;
    endtask

    initial begin
        nvec     = 0;
        nerr     = 0;
        rst      = 1'b0;
        sel      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        model_clear();

        // Reset defaults with sel toggling.
        for (int i = 0; i < 6; i++) begin
            sel = ~sel;
            @(posedge clk);
            #1;
            check_all("rst_dflt");
        end
        sel = 1'b0;
        rst = 1'b1;

        // In-order delivery.
        cycle(1'b1, 8'h11, 1'b0, "push");
        cycle(1'b1, 8'h22, 1'b0, "push");
        cycle(1'b1, 8'h33, 1'b0, "push");
        cycle(1'b0, 8'h00, 1'b1, "ord");
        chk("ord_first", {24'd0, data}, 32'h11);
        cycle(1'b0, 8'h00, 1'b1, "ord");
        cycle(1'b0, 8'h00, 1'b0, "ord");
        cycle(1'b0, 8'h00, 1'b0, "ord");
        cycle(1'b0, 8'h00, 1'b1, "ord");
        chk("ord_second", {24'd0, data}, 32'h22);
        cycle(1'b0, 8'h00, 1'b1, "ord");
        cycle(1'b0, 8'h00, 1'b0, "ord");
        cycle(1'b0, 8'h00, 1'b0, "ord");
        cycle(1'b0, 8'h00, 1'b1, "ord");
        chk("ord_third", {24'd0, data}, 32'h33);
        chk("ord_run", {30'd0, link_state}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, "ord");

        // Underrun and recovery.
        cycle(1'b0, 8'h00, 1'b1, "und");
        cycle(1'b0, 8'h00, 1'b0, "und");
        cycle(1'b0, 8'h00, 1'b1, "und");
        cycle(1'b0, 8'h00, 1'b0, "und");
        chk("und_cnt", {24'd0, underrun_cnt}, 32'd2);
        chk("und_starved", {30'd0, link_state}, 32'd2);
        chk("und_hold", {24'd0, data}, 32'h33);
        cycle(1'b1, 8'h5A, 1'b0, "rec");
        cycle(1'b0, 8'h00, 1'b1, "rec");
        chk("rec_data", {24'd0, data}, 32'h5A);
        chk("rec_run", {30'd0, link_state}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, "rec");

        // Full handling: fifth word is refused.
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 8'hA0 + 8'(i), 1'b0, "full");
            if (i == 4) chk("full_ready", {31'd0, in_ready}, 32'd0);
        end
        cycle(1'b0, 8'h00, 1'b1, "full_pop");
        chk("full_pop_data", {24'd0, data}, 32'hA1);
        chk("full_pop_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'(i % 2 == 0), "drain");

        // Push into empty FIFO in the same cycle as a request.
        cycle(1'b1, 8'hC3, 1'b1, "simul");
        cycle(1'b0, 8'h00, 1'b0, "simul");
        cycle(1'b0, 8'h00, 1'b1, "simul");
        chk("simul_data", {24'd0, data}, 32'hC3);
        cycle(1'b0, 8'h00, 1'b0, "simul");

        // Reset with two words queued; the next request must underrun.
        cycle(1'b1, 8'h71, 1'b0, "pre_rst");
        cycle(1'b1, 8'h72, 1'b0, "pre_rst");
        do_reset();
        cycle(1'b0, 8'h00, 1'b1, "post_rst");
        chk("post_rst_ucnt", {24'd0, underrun_cnt}, 32'd1);
        chk("post_rst_data", {24'd0, data}, 32'd0);
        cycle(1'b0, 8'h00, 1'b0, "post_rst");

        // Sel already high when reset releases counts as a request.
        rst = 1'b0;
        model_clear();
        sel = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b1, "rel_high");
        chk("rel_high_ucnt", {24'd0, underrun_cnt}, 32'd1);

        // Saturation.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 8'h00, 1'b1, "sat");
            cycle(1'b0, 8'h00, 1'b0, "sat");
        end
        chk("sat_cnt", {24'd0, underrun_cnt}, 32'd255);
        chk("sat_idle", {30'd0, link_state}, 32'd0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
